counter_monitor: RTL
====================

Name: counter_monitor

Overview:
- Sits directly downstream of the 8-bit up/down counter.
- Samples the counter value every clock cycle.
- Classifies each step as up, down, hold or illegal.
- Tracks net wrap-arounds to build an extended position.
- Pulses on a programmable match value.
- Offers a one-entry snapshot of the extended position to a consumer over a req/ack handshake.

Parameters:
- CNT_W, 8, width of the monitored counter value.
- WRAP_W, 16, width of the signed net-wrap accumulator.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- count_in  in  CNT_W  counter value from the upstream counter.
- dir_in  in  1  upstream direction (1 = up).
- src_rst  in  1  upstream counter reset (active-high), sampled synchronously; forces re-prime.
- clear  in  1  synchronous clear of accumulator and sticky flags.
- match_val  in  CNT_W  compare value.
- snap_req  in  1  request snapshot capture (single-cycle pulse or level).
- snap_ack  in  1  consumer accepts snap_data.
- pos_out  out  WRAP_W+CNT_W  extended position {wraps, count}.
- wrap_up_p  out  1  one-cycle pulse on 2^CNT_W-1 -> 0.
- wrap_dn_p  out  1  one-cycle pulse on 0 -> 2^CNT_W-1.
- match_p  out  1  one-cycle pulse on arrival at match_val.
- step_err  out  1  sticky illegal-step flag.
- snap_data  out  WRAP_W+CNT_W  captured position.
- snap_valid  out  1  snapshot holding valid data.
- snap_ovr  out  1  sticky flag: request dropped while full.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, wraps=0, prev=0, tracker state UNPRIMED, snapshot state EMPTY.
- All outputs are registered. Results for sample N appear after the clock edge that samples N (1-cycle latency).

Tracker FSM (UNPRIMED, TRACK):
- UNPRIMED: latch prev<=count_in. No pulses, no error. Go to TRACK.
- TRACK, step classification of count_in vs prev, modulo 2^CNT_W:
  - equal: hold.
  - +1: up step; wrap_up_p=1 if prev=max and count_in=0.
  - -1: down step; wrap_dn_p=1 if prev=0 and count_in=max.
  - any other delta: step_err set. prev still updates; no wrap counted.
  - up step with dir_in=0, or down step with dir_in=1: step_err set.
- src_rst=1, any state: wraps<=0, state<=UNPRIMED, no pulses, no error. This has priority over step classification.

Wrap accumulator:
- wraps is signed WRAP_W bits: +1 on wrap up, -1 on wrap down.
- Saturates at +2^(WRAP_W-1)-1 and -2^(WRAP_W-1); no wrap at the limits.

Outputs:
- pos_out <= {wraps_next, count_in} every cycle, including UNPRIMED.
- match_p=1 when in TRACK, count_in==match_val and count_in!=prev. Holding on match_val does not re-pulse.

clear:
- Sets wraps<=0, step_err<=0, snap_ovr<=0.
- Does not change tracker state, prev or snapshot contents.
- clear with a simultaneous wrap: clear wins (wraps=0).
- clear with a simultaneous illegal step: step_err=0.

Snapshot FSM (EMPTY, FULL):
- EMPTY + snap_req: snap_data<=pos_out_next, snap_valid<=1, go to FULL.
- FULL + snap_ack, no req: snap_valid<=0, go to EMPTY.
- FULL + snap_ack + snap_req: recapture, stay FULL, no overrun.
- FULL + snap_req, no ack: request dropped, data unchanged, snap_ovr<=1.
- EMPTY + snap_ack: ignored.
- snap_data stays stable while snap_valid=1.

Mid-operation reset: rst=0 at any time returns everything to the reset values immediately. The first post-reset sample only primes.

Decomposition:
- Shared package holds:
  - CNT_W, WRAP_W defaults;
  - tracker state enum {UNPRIMED, TRACK};
  - snapshot state enum {EMPTY, FULL};
  - step-class enum {HOLD, UP, DOWN, ILLEGAL}.
- One natural sub-module: counter_step_classifier. It is combinational, takes prev, count_in and dir_in, and outputs step class, wrap_up, wrap_dn and dir_mismatch.
- Accumulator, flags and snapshot FSM stay in the top module.

Test Plan:
- rst low, then high, count_in ramps 250..255,0,1 with dir_in=1:
  - first cycle primes only;
  - wrap_up_p one pulse after the 255->0 sample;
  - pos_out = 0x000100 then 0x000101.
- count_in 1,0,255,254 with dir_in=0:
  - wrap_dn_p one pulse;
  - pos_out = 0xFFFFFF, then 0xFFFFFE.
- count_in jumps 10->13: step_err=1 and stays set. Then clear=1 for one cycle: step_err=0, wraps=0.
- match_val=0x80, count 0x7E,0x7F,0x80,0x80,0x81: match_p exactly one pulse, 1 cycle after the 0x80 arrival.
- snap_req at pos 0x000105, snap_ack held low, then a second snap_req:
  - snap_valid=1, snap_data=0x000105 unchanged;
  - snap_ovr=1;
  - then snap_ack=1: snap_valid=0.
- Upstream counter forced to wrap up 3 times, then src_rst=1 with count_in=0:
  - wraps=0, no step_err;
  - next sample re-primes;
  - rst asserted mid-snapshot clears snap_valid immediately.

Source files
------------

// File: rtl/counter_monitor_pkg.sv
// Shared types and default widths for the counter monitor slice.
//   DEF_CNT_W / DEF_WRAP_W : default counter and wrap-accumulator widths
//   trk_state_e            : wrap tracker states
//   snap_state_e           : snapshot slot states
//   step_class_e           : classification of one counter step
package counter_monitor_pkg;

  localparam int unsigned DEF_CNT_W  = 8;
  localparam int unsigned DEF_WRAP_W = 16;

  typedef enum logic {
    UNPRIMED = 1'b0,
    TRACK    = 1'b1
  } trk_state_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } snap_state_e;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    UP      = 2'd1,
    DOWN    = 2'd2,
    ILLEGAL = 2'd3
  } step_class_e;

endpackage

// File: rtl/counter_monitor_if.sv
// Snapshot handshake between the monitor (master) and a consumer (slave).
//   snap_req   : consumer asks for a capture of the extended position
//   snap_ack   : consumer accepts snap_data
//   snap_data  : captured extended position {wraps, count}
//   snap_valid : snap_data holds an unconsumed capture
//   snap_ovr   : sticky, a request was dropped while the slot was full
interface counter_monitor_if #(
  parameter int unsigned POS_W = counter_monitor_pkg::DEF_CNT_W + counter_monitor_pkg::DEF_WRAP_W
) ();

  logic             snap_req;
  logic             snap_ack;
  logic [POS_W-1:0] snap_data;
  logic             snap_valid;
  logic             snap_ovr;

  modport master (
    input  snap_req,
    input  snap_ack,
    output snap_data,
    output snap_valid,
    output snap_ovr
  );

  modport slave (
    output snap_req,
    output snap_ack,
    input  snap_data,
    input  snap_valid,
    input  snap_ovr
  );

endinterface

// File: rtl/counter_step_classifier.sv
// Combinational classification of one counter step (prev -> count_in).
//   prev, count_in : previous and current counter samples
//   dir_in         : upstream direction, 1 = up
//   step_class_c   : HOLD / UP / DOWN / ILLEGAL (modulo 2^CNT_W)
//   wrap_up_c      : up step from max to 0
//   wrap_dn_c      : down step from 0 to max
//   dir_mismatch_c : step direction disagrees with dir_in
module counter_step_classifier
  import counter_monitor_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic [CNT_W-1:0] prev,
  input  logic [CNT_W-1:0] count_in,
  input  logic             dir_in,
  output step_class_e      step_class_c,
  output logic             wrap_up_c,
  output logic             wrap_dn_c,
  output logic             dir_mismatch_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] delta;

  // Modular difference; all-ones is a step of -1.
  assign delta = count_in - prev;

  always_comb begin
    step_class_c = ILLEGAL;
    if (delta == '0) begin
      step_class_c = HOLD;
    end else if (delta == CNT_W'(1)) begin
      step_class_c = UP;
    end else if (delta == CNT_MAX) begin
      step_class_c = DOWN;
    end
  end

  // A +1 step out of max necessarily lands on 0, and a -1 step out of 0 lands on max.
  assign wrap_up_c      = (step_class_c == UP)   && (prev == CNT_MAX);
  assign wrap_dn_c      = (step_class_c == DOWN) && (prev == '0);
  assign dir_mismatch_c = ((step_class_c == UP) && !dir_in) || ((step_class_c == DOWN) && dir_in);

endmodule

// File: rtl/counter_monitor.sv
// Monitors an up/down counter: classifies steps, accumulates net wraps into an
// extended position, pulses on a match value and offers a one-entry snapshot.
//   clk, rst            : clock, asynchronous active-low reset
//   count_in, dir_in    : upstream counter value and direction
//   src_rst             : upstream counter reset, forces re-prime
//   clear               : clears wrap accumulator and sticky flags
//   match_val           : compare value for match_p
//   pos_out             : extended position {wraps, count}
//   wrap_up_p/wrap_dn_p : wrap pulses
//   match_p             : pulse on arrival at match_val
//   step_err            : sticky illegal-step flag
//   snap                : snapshot handshake (master side)
module counter_monitor #(
  parameter int unsigned CNT_W  = counter_monitor_pkg::DEF_CNT_W,
  parameter int unsigned WRAP_W = counter_monitor_pkg::DEF_WRAP_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CNT_W-1:0]        count_in,
  input  logic                    dir_in,
  input  logic                    src_rst,
  input  logic                    clear,
  input  logic [CNT_W-1:0]        match_val,
  output logic [WRAP_W+CNT_W-1:0] pos_out,
  output logic                    wrap_up_p,
  output logic                    wrap_dn_p,
  output logic                    match_p,
  output logic                    step_err,
  counter_monitor_if.master       snap
);
  import counter_monitor_pkg::*;

  localparam int unsigned POS_W = WRAP_W + CNT_W;
  localparam logic [WRAP_W-1:0] WRAP_MAX = {1'b0, {(WRAP_W-1){1'b1}}};
  localparam logic [WRAP_W-1:0] WRAP_MIN = {1'b1, {(WRAP_W-1){1'b0}}};

  trk_state_e        trk_q, trk_d;
  snap_state_e       snp_q, snp_d;
  logic [CNT_W-1:0]  prev_q;
  logic [WRAP_W-1:0] wraps_q, wraps_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [POS_W-1:0]  snap_data_q, snap_data_d;
  logic              wrap_up_q, wrap_up_d;
  logic              wrap_dn_q, wrap_dn_d;
  logic              match_q, match_d;
  logic              err_q, err_d;
  logic              snap_valid_q, snap_valid_d;
  logic              ovr_q, ovr_d;

  step_class_e       cls_c;
  logic              wrap_up_c, wrap_dn_c, dir_mismatch_c;

  counter_step_classifier #(
    .CNT_W (CNT_W)
  ) u_classifier (
    .prev           (prev_q),
    .count_in       (count_in),
    .dir_in         (dir_in),
    .step_class_c   (cls_c),
    .wrap_up_c      (wrap_up_c),
    .wrap_dn_c      (wrap_dn_c),
    .dir_mismatch_c (dir_mismatch_c)
  );

  // Next-state and output logic for tracker, accumulator, flags and snapshot.
  always_comb begin
    trk_d        = trk_q;
    snp_d        = snp_q;
    wraps_d      = wraps_q;
    err_d        = err_q;
    ovr_d        = ovr_q;
    snap_data_d  = snap_data_q;
    snap_valid_d = snap_valid_q;
    wrap_up_d    = 1'b0;
    wrap_dn_d    = 1'b0;
    match_d      = 1'b0;

    if (src_rst) begin
      trk_d   = UNPRIMED;
      wraps_d = '0;
    end else if (trk_q == UNPRIMED) begin
      trk_d = TRACK;
    end else begin
      wrap_up_d = wrap_up_c;
      wrap_dn_d = wrap_dn_c;
      match_d   = (count_in == match_val) && (count_in != prev_q);
      if ((cls_c == ILLEGAL) || dir_mismatch_c) begin
        err_d = 1'b1;
      end
      // Saturate rather than wrap the accumulator at its signed limits.
      if (wrap_up_c && (wraps_q != WRAP_MAX)) begin
        wraps_d = wraps_q + WRAP_W'(1);
      end else if (wrap_dn_c && (wraps_q != WRAP_MIN)) begin
        wraps_d = wraps_q - WRAP_W'(1);
      end
    end

    if (clear) begin
      wraps_d = '0;
      err_d   = 1'b0;
    end

    pos_d = {wraps_d, count_in};

    case (snp_q)
      EMPTY: begin
        if (snap.snap_req) begin
          snap_data_d  = pos_d;
          snap_valid_d = 1'b1;
          snp_d        = FULL;
        end
      end
      FULL: begin
        if (snap.snap_ack && snap.snap_req) begin
          snap_data_d = pos_d;
        end else if (snap.snap_ack) begin
          snap_valid_d = 1'b0;
          snp_d        = EMPTY;
        end else if (snap.snap_req) begin
          ovr_d = 1'b1;
        end
      end
      default: snp_d = EMPTY;
    endcase

    if (clear) begin
      ovr_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trk_q        <= UNPRIMED;
      snp_q        <= EMPTY;
      prev_q       <= '0;
      wraps_q      <= '0;
      pos_q        <= '0;
      snap_data_q  <= '0;
      wrap_up_q    <= 1'b0;
      wrap_dn_q    <= 1'b0;
      match_q      <= 1'b0;
      err_q        <= 1'b0;
      snap_valid_q <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      trk_q        <= trk_d;
      snp_q        <= snp_d;
      prev_q       <= count_in;
      wraps_q      <= wraps_d;
      pos_q        <= pos_d;
      snap_data_q  <= snap_data_d;
      wrap_up_q    <= wrap_up_d;
      wrap_dn_q    <= wrap_dn_d;
      match_q      <= match_d;
      err_q        <= err_d;
      snap_valid_q <= snap_valid_d;
      ovr_q        <= ovr_d;
    end
  end

  assign pos_out         = pos_q;
  assign wrap_up_p       = wrap_up_q;
  assign wrap_dn_p       = wrap_dn_q;
  assign match_p         = match_q;
  assign step_err        = err_q;
  assign snap.snap_data  = snap_data_q;
  assign snap.snap_valid = snap_valid_q;
  assign snap.snap_ovr   = ovr_q;

endmodule
